data_mem_ctrl: RTL
==================

# data_mem_ctrl

Data-side memory controller between the CPU load/store unit and the word-organised 4096×32 RAM. It converts byte-addressed load/store requests of byte, halfword or word size into word RAM accesses:
- extracts and sign- or zero-extends load data;
- performs read-modify-write for sub-word stores;
- flags misaligned and out-of-range accesses.

It drives the RAM data port (address, write data, write enable) and consumes the RAM's registered one-cycle-latency data read output.

## Interface
- ADDR_W, 12, RAM word-address width (RAM depth 2^ADDR_W words)
- clk  in  1  system clock, rising edge
- nrst  in  1  asynchronous active-low reset
- cpu_read  in  1  load request; sampled only while cpu_busy=0
- cpu_write  in  1  store request; sampled only while cpu_busy=0
- cpu_addr  in  32  byte address
- cpu_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- cpu_unsigned  in  1  1 = zero-extend load, 0 = sign-extend
- cpu_wdata  in  32  store data, low bytes used for sub-word stores
- cpu_busy  out  1  transaction in progress; high in every non-IDLE state
- cpu_done  out  1  one-cycle completion pulse
- cpu_fault  out  1  valid with cpu_done; access rejected, RAM untouched
- cpu_rdata  out  32  load result, valid with cpu_done, held until next load completes
- ram_addr  out  ADDR_W  word address = cpu_addr[ADDR_W+1:2] (latched)
- ram_wdata  out  32  word to write (registered)
- ram_we  out  1  write enable; high only in state WR
- ram_rdata  in  32  RAM read word; reflects the ram_addr of the previous cycle (pre-write contents)

## Operation
- States: IDLE, RD, CAP, WR.
- IDLE acceptance: request seen when cpu_busy=0. All request fields are latched on that edge.
- Fault, checked at acceptance; any of the following faults the request:
  - both cpu_read and cpu_write high;
  - cpu_size=11;
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0;
  - addr[31:ADDR_W+2]≠0.
- On fault: stay IDLE, pulse cpu_done=1 with cpu_fault=1 next cycle, no RAM access, cpu_rdata unchanged.
- Load: IDLE→RD→CAP→IDLE.
  - In CAP, select from ram_rdata: byte lane addr[1:0], or half lane addr[1] (bits 16*addr[1]+15:16*addr[1]).
  - Extend per cpu_unsigned and register into cpu_rdata on the CAP→IDLE edge.
- Word store: IDLE→WR→IDLE. ram_wdata = cpu_wdata, latched at acceptance.
- Sub-word store: IDLE→RD→CAP→WR→IDLE.
  - On the CAP→WR edge, ram_wdata = ram_rdata with the target lane replaced by cpu_wdata[7:0] (byte) or cpu_wdata[15:0] (half); other bytes preserved.
- cpu_done pulses for exactly one cycle, in the first IDLE cycle after the final state.
- Requests arriving while cpu_busy=1 are ignored, not queued. A new request may be accepted in the same cycle cpu_done is high.
- I/O-mapped words (4090–4095) are accessed like any other word; no special handling.
- Reset (async, nrst=0), immediately:
  - state→IDLE;
  - ram_we=0, cpu_busy=0, cpu_done=0, cpu_fault=0;
  - cpu_rdata=0, ram_wdata=0, ram_addr=0.
- Reset mid-transaction abandons it with no done pulse. If in WR, the write may or may not land, depending on edge alignment.

## Timing
Request sampled at edge 0; Cn denotes the cycle after edge n.
- Word store: WR in C1 (ram_we=1); cpu_done in C2. Latency 2.
- Load: RD in C1, CAP in C2 (ram_rdata valid); cpu_done and cpu_rdata in C3. Latency 3.
- Sub-word store: RD C1, CAP C2, WR C3; cpu_done in C4. Latency 4.
- Fault: cpu_done with cpu_fault in C1. Latency 1.
- ram_addr is stable from C1 until the next acceptance.
- ram_we is a decode of state WR only; never high in any other state.
- Throughput: back-to-back word stores every 2 cycles, loads every 3.

## Test plan
- Word store 0xDEADBEEF to 0x100, then word load 0x100:
  - ram_we high in exactly one cycle, with ram_addr=0x040;
  - load cpu_done 3 cycles after request, cpu_rdata=0xDEADBEEF, cpu_fault=0.
- Byte store 0xA5 to 0x102 over word 0x11223344:
  - RAM word becomes 0x11A53344; done at latency 4;
  - signed byte load 0x102 → 0xFFFFFFA5; unsigned → 0x000000A5.
- Halfword 0x8001 stored to 0x206, then signed half load 0x206 → 0xFFFF8001; unsigned → 0x00008001; bytes 0x204–0x205 unchanged.
- Faults:
  - half at 0x101, word at 0x102, size=11, address 0x00004000, read+write together: each gives cpu_done=cpu_fault=1 at latency 1, ram_we never high, cpu_rdata unchanged;
  - a subsequent legal load succeeds.
- Request pulsed while cpu_busy=1 during a load: ignored; exactly one cpu_done.
- nrst asserted during CAP of a sub-word store:
  - outputs go to reset values without waiting for a clock edge;
  - no cpu_done; RAM word unchanged;
  - next request after release completes normally.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Data-side memory controller: turns byte/half/word load-store requests into
// word accesses on a one-cycle-latency RAM, with read-modify-write for sub-word stores.
module data_mem_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_addr,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_unsigned,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic              cpu_fault,
  output logic [31:0]       cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2,
    WR   = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  state_t      state;
  state_t      state_next;
  logic        done_next;
  logic        fault_next;
  logic        req;
  logic        accept;
  logic        bad_access;

  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic        write_q;
  logic [15:0] wdata_q;

  logic [31:0] lane_shifted;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;
  logic [31:0] merge_mask;
  logic [31:0] merge_ins;
  logic [31:0] merged_word;

  assign cpu_busy = (state != IDLE);
  assign ram_we   = (state == WR);
  assign req      = cpu_read | cpu_write;
  assign accept   = (state == IDLE) && req;

  // Any one of these rejects the request before the RAM is touched.
  always_comb begin
    bad_access = 1'b0;
    if (cpu_read && cpu_write)                             bad_access = 1'b1;
    if (cpu_size == SIZE_BAD)                              bad_access = 1'b1;
    if (cpu_size == SIZE_HALF && cpu_addr[0])              bad_access = 1'b1;
    if (cpu_size == SIZE_WORD && cpu_addr[1:0] != 2'b00)   bad_access = 1'b1;
    if (|cpu_addr[31:ADDR_W+2])                            bad_access = 1'b1;
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    fault_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (bad_access) begin
            done_next  = 1'b1;
            fault_next = 1'b1;
          end else if (cpu_write && cpu_size == SIZE_WORD) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD: state_next = CAP;
      CAP: begin
        if (write_q) begin
          state_next = WR;
        end else begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      WR: begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_next;
  end

  // Load path: pick the addressed lane out of the returned word, then extend.
  always_comb begin
    lane_shifted = ram_rdata >> {lane_q, 3'b000};
    sel_byte     = lane_shifted[7:0];
    sel_half     = lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    unique case (size_q)
      SIZE_BYTE: load_data = {{24{~unsigned_q & sel_byte[7]}}, sel_byte};
      SIZE_HALF: load_data = {{16{~unsigned_q & sel_half[15]}}, sel_half};
      default:   load_data = ram_rdata;
    endcase
  end

  // Store path: replace only the target lane, keep the other bytes of the old word.
  always_comb begin
    if (size_q == SIZE_BYTE) begin
      merge_mask = 32'h0000_00FF << {lane_q, 3'b000};
      merge_ins  = {4{wdata_q[7:0]}};
    end else begin
      merge_mask = 32'h0000_FFFF << {lane_q[1], 4'b0000};
      merge_ins  = {2{wdata_q}};
    end
    merged_word = (ram_rdata & ~merge_mask) | (merge_ins & merge_mask);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cpu_done   <= 1'b0;
      cpu_fault  <= 1'b0;
      cpu_rdata  <= 32'd0;
      ram_addr   <= '0;
      ram_wdata  <= 32'd0;
      lane_q     <= 2'b00;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      write_q    <= 1'b0;
      wdata_q    <= 16'd0;
    end else begin
      cpu_done  <= done_next;
      cpu_fault <= fault_next;
      if (accept && !bad_access) begin
        ram_addr   <= cpu_addr[ADDR_W+1:2];
        lane_q     <= cpu_addr[1:0];
        size_q     <= cpu_size;
        unsigned_q <= cpu_unsigned;
        write_q    <= cpu_write;
        wdata_q    <= cpu_wdata[15:0];
        if (cpu_write) ram_wdata <= cpu_wdata;
      end
      if (state == CAP) begin
        if (write_q) ram_wdata <= merged_word;
        else         cpu_rdata <= load_data;
      end
    end
  end

endmodule
